codec_config_sequencer: RTL and testbench

CODEC_CONFIG_SEQUENCER -- requirements
Module: codec_config_sequencer

---
 rtl/codec_cfg_pkg.sv | 25 ++
 rtl/codec_config_sequencer_if.sv | 10 +
 rtl/codec_cfg_rom.sv | 14 +
 rtl/codec_config_sequencer.sv | 135 +++++++++++++
 tb/tb_codec_config_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio codec register-configuration sequencer.
// Holds the FSM state encoding and the ordered register-write table.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    GAP,
    DONE,
    ERROR
  } seq_state_t;

  localparam int         NUM_WORDS  = 11;
  localparam logic [3:0] LAST_INDEX = 4'(NUM_WORDS - 1);
  localparam logic [2:0] ACK_ALL    = 3'b111;

  // Each entry is {reg_addr[6:0], reg_data[8:0]}, written in this order.
  localparam logic [15:0] CFG_TABLE [NUM_WORDS] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E01, 16'h1000, 16'h1201
  };

endpackage

// File: rtl/codec_config_sequencer_if.sv
// Handshake between the configuration sequencer (master) and the I2C engine (slave).
interface codec_config_sequencer_if;
  logic [15:0] cfg_word;
  logic        ignition;
  logic        finish_flag;
  logic [2:0]  ack;

  modport master (output cfg_word, ignition, input finish_flag, ack);
  modport slave  (input cfg_word, ignition, output finish_flag, ack);
endinterface

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of the configuration table; indices past the end read as zero.
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    if (int'(index) < NUM_WORDS) word = CFG_TABLE[index];
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec register table through an external I2C engine, one word per
// transaction, with per-word retry, a per-transaction timeout and an idle gap.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  codec_config_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [3:0]                      word_index
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_t       state, state_n;
  logic [3:0]       word_index_n;
  logic [RTY_W-1:0] retry, retry_n;
  logic [15:0]      cfg_word, cfg_word_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             ack_ok, ack_ok_n;
  logic             finish_prev;
  logic             finish_rise;
  logic [15:0]      rom_word;

  codec_cfg_rom u_rom (
    .index (word_index),
    .word  (rom_word)
  );

  // finish_prev tracks the flag in every state, so a level left high from an
  // earlier transaction never looks like a fresh rising edge once RUN begins.
  assign finish_rise = bus.finish_flag & ~finish_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word_index  <= 4'd0;
      retry       <= '0;
      cfg_word    <= 16'h0000;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      ack_ok      <= 1'b0;
      finish_prev <= 1'b0;
    end else begin
      state       <= state_n;
      word_index  <= word_index_n;
      retry       <= retry_n;
      cfg_word    <= cfg_word_n;
      to_cnt      <= to_cnt_n;
      gap_cnt     <= gap_cnt_n;
      ack_ok      <= ack_ok_n;
      finish_prev <= bus.finish_flag;
    end
  end

  always_comb begin
    state_n      = state;
    word_index_n = word_index;
    retry_n      = retry;
    cfg_word_n   = cfg_word;
    to_cnt_n     = to_cnt;
    gap_cnt_n    = gap_cnt;
    ack_ok_n     = ack_ok;

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_n      = LOAD;
          word_index_n = 4'd0;
          retry_n      = '0;
        end
      end
      LOAD: begin
        cfg_word_n = rom_word;
        to_cnt_n   = '0;
        state_n    = RUN;
      end
      RUN: begin
        // A real completion edge wins over a timeout landing on the same cycle.
        if (finish_rise) begin
          ack_ok_n = (bus.ack == ACK_ALL);
          state_n  = CHECK;
        end else if (to_cnt == TO_LAST) begin
          ack_ok_n = 1'b0;
          state_n  = CHECK;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      CHECK: begin
        gap_cnt_n = '0;
        if (ack_ok) begin
          retry_n = '0;
          if (word_index == LAST_INDEX) begin
            state_n = DONE;
          end else begin
            word_index_n = word_index + 4'd1;
            state_n      = GAP;
          end
        end else if ((retry + RTY_W'(1)) < RTY_MAX) begin
          retry_n = retry + RTY_W'(1);
          state_n = GAP;
        end else begin
          state_n = ERROR;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = LOAD;
        else                     gap_cnt_n = gap_cnt + GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ignition = (state == RUN);
  assign bus.cfg_word = cfg_word;
  assign busy         = (state == LOAD) || (state == RUN) || (state == CHECK) || (state == GAP);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural I2C engine responder.
module tb_codec_config_sequencer;

  localparam int GAP_T = 4;
  localparam int TO_T  = 100;

  localparam logic [15:0] EXP_TABLE [11] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E01, 16'h1000, 16'h1201
  };

  typedef enum int {F_NONE, F_RETRY, F_EXHAUST, F_TIMEOUT} fault_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, error;
  logic [3:0] word_index;

  logic       model_en;
  logic       model_flag, manual_flag;
  logic [2:0] model_ack, manual_ack;
  fault_t     fault;
  int         seen_0479;
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  codec_config_sequencer_if bus ();

  assign bus.finish_flag = model_en ? model_flag : manual_flag;
  assign bus.ack         = model_en ? model_ack  : manual_ack;

  codec_config_sequencer #(
    .GAP_CYCLES     (GAP_T),
    .TIMEOUT_CYCLES (TO_T),
    .MAX_RETRY      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_index (word_index)
  );

  always #5 clk = ~clk;

  // Engine model: logs each requested word and answers two cycles later unless told not to.
  initial begin : responder
    logic [15:0] w;
    logic [2:0]  rsp_ack;
    logic        silent;
    model_flag = 1'b0;
    model_ack  = 3'b000;
    forever begin
      @(negedge clk);
      if (model_en && bus.ignition) begin
        w = bus.cfg_word;
        log_q.push_back(w);
        rsp_ack = 3'b111;
        silent  = 1'b0;
        if (fault == F_RETRY && w == 16'h0479) begin
          seen_0479++;
          if (seen_0479 == 1) rsp_ack = 3'b101;
        end
        if (fault == F_EXHAUST && w == 16'h0812) rsp_ack = 3'b011;
        if (fault == F_TIMEOUT && w == 16'h1E00) silent = 1'b1;
        repeat (2) @(negedge clk);
        if (!silent && bus.ignition) begin
          model_ack  = rsp_ack;
          model_flag = 1'b1;
        end
        while (bus.ignition) @(negedge clk);
        model_flag = 1'b0;
        model_ack  = 3'b000;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    int n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    timed_out = !(done || error);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    model_en = 1'b1;
    manual_flag = 1'b0;
    manual_ack = 3'b000;
    fault = F_NONE;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ignition !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ignition got %b want 0", bus.ignition); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error got %b want 0", error); end
    vectors++; if (word_index !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_index got %0d want 0", word_index); end
    vectors++; if (bus.cfg_word !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_cfg_word got %h want 0000", bus.cfg_word); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    bit to;
    fault = F_NONE;
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(EXP_TABLE[i]);
    pulse_start();
    wait_end(to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL nominal_wait got timeout want done"); end
    vectors++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL nominal_flags got done=%b error=%b busy=%b want 1/0/0", done, error, busy); end
    vectors++; if (word_index !== 4'd10) begin miscompares++; $display("[TB] FAIL nominal_index got %0d want 10", word_index); end
    vectors++; if (log_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL nominal_count got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      logic [15:0] got;
      got = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL nominal_word[%0d] got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_retry();
    bit to;
    fault = F_RETRY;
    seen_0479 = 0;
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(EXP_TABLE[i]);
      if (i == 3) exp_q.push_back(EXP_TABLE[i]);
    end
    pulse_start();
    wait_end(to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL retry_wait got timeout want done"); end
    vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL retry_flags got done=%b error=%b want 1/0", done, error); end
    vectors++; if (log_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL retry_count got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      logic [15:0] got;
      got = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL retry_word[%0d] got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_exhaust();
    bit to;
    fault = F_EXHAUST;
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(EXP_TABLE[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0812);
    pulse_start();
    wait_end(to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL exhaust_wait got timeout want error"); end
    vectors++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bus.ignition !== 1'b0) begin miscompares++; $display("[TB] FAIL exhaust_flags got error=%b done=%b busy=%b ign=%b want 1/0/0/0", error, done, busy, bus.ignition); end
    vectors++; if (word_index !== 4'd5) begin miscompares++; $display("[TB] FAIL exhaust_index got %0d want 5", word_index); end
    vectors++; if (log_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL exhaust_count got %0d want %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      logic [15:0] got;
      got = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL exhaust_word[%0d] got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    int n, hi, lo;
    fault = F_TIMEOUT;
    log_q.delete();
    pulse_start();
    n = 0;
    while (!bus.ignition && n < 50) begin @(negedge clk); n++; end
    hi = 0;
    while (bus.ignition && hi < 500) begin hi++; @(negedge clk); end
    lo = 0;
    while (!bus.ignition && lo < 500) begin lo++; @(negedge clk); end
    vectors++; if (hi != TO_T) begin miscompares++; $display("[TB] FAIL timeout_high_cycles got %0d want %0d", hi, TO_T); end
    vectors++; if (lo != GAP_T + 2) begin miscompares++; $display("[TB] FAIL timeout_low_cycles got %0d want %0d", lo, GAP_T + 2); end
    wait_end(to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL timeout_wait got timeout want error"); end
    vectors++; if (error !== 1'b1 || done !== 1'b0 || word_index !== 4'd0) begin miscompares++; $display("[TB] FAIL timeout_flags got error=%b done=%b idx=%0d want 1/0/0", error, done, word_index); end
    vectors++; if (log_q.size() != 3) begin miscompares++; $display("[TB] FAIL timeout_attempts got %0d want 3", log_q.size()); end
    foreach (log_q[i]) begin
      vectors++; if (log_q[i] !== 16'h1E00) begin miscompares++; $display("[TB] FAIL timeout_word[%0d] got %h want 1e00", i, log_q[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int n;
    fault = F_NONE;
    pulse_start();
    n = 0;
    while (!(bus.ignition && word_index == 4'd4) && n < 1000) begin @(negedge clk); n++; end
    vectors++; if (!(bus.ignition && word_index == 4'd4)) begin miscompares++; $display("[TB] FAIL midrun_reach got idx=%0d ign=%b want 4/1", word_index, bus.ignition); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (bus.ignition !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_ignition got %b want 0", bus.ignition); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_flags got busy=%b done=%b error=%b want 0/0/0", busy, done, error); end
    vectors++; if (word_index !== 4'd0 || bus.cfg_word !== 16'h0000) begin miscompares++; $display("[TB] FAIL midrun_regs got idx=%0d word=%h want 0/0000", word_index, bus.cfg_word); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrun_no_resume got busy=%b want 0", busy); end
    reset = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.ignition && n < 50) begin @(negedge clk); n++; end
    vectors++; if (bus.cfg_word !== 16'h1E00 || bus.ignition !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_restart got word=%h ign=%b want 1e00/1", bus.cfg_word, bus.ignition); end
    wait_end(to);
    vectors++; if (to || done !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_finish got done=%b want 1", done); end
  endtask

  task automatic test_stale_flag();
    int n;
    model_en = 1'b0;
    @(negedge clk);
    manual_ack  = 3'b111;
    manual_flag = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.ignition && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    vectors++; if (bus.ignition !== 1'b1 || word_index !== 4'd0) begin miscompares++; $display("[TB] FAIL stale_ignored got ign=%b idx=%0d want 1/0", bus.ignition, word_index); end
    pulse_start();
    vectors++; if (bus.ignition !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_start_in_run got ign=%b busy=%b want 1/1", bus.ignition, busy); end
    manual_flag = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.ignition !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_fall got ign=%b want 1", bus.ignition); end
    manual_flag = 1'b1;
    @(negedge clk);
    vectors++; if (bus.ignition !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_rise got ign=%b busy=%b want 0/1", bus.ignition, busy); end
    manual_flag = 1'b0;
    @(negedge clk);
    vectors++; if (word_index !== 4'd1) begin miscompares++; $display("[TB] FAIL stale_advance got idx=%0d want 1", word_index); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (word_index !== 4'd1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_start_in_gap got idx=%0d busy=%b want 1/1", word_index, busy); end
    n = 0;
    while (!bus.ignition && n < 50) begin @(negedge clk); n++; end
    vectors++; if (bus.cfg_word !== 16'h0017 || bus.ignition !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_next_word got word=%h ign=%b want 0017/1", bus.cfg_word, bus.ignition); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_nominal();
    test_retry();
    test_exhaust();
    test_timeout();
    test_reset_mid_run();
    test_stale_flag();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
